// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - RV32I load/store unit between the MEM stage and dmem
// Decodes funct3/byte address into dmem lane codes and merges sub-word stores by read-modify-write.
module lsu_ctrl #(
  parameter int ADDR_WIDTH = 15,
  parameter bit RMW_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [3:0]  mem_wmem,
  output logic [4:0]  mem_rmem,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_store_data,
  input  logic [31:0] mem_load_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STORE, S_RMW_RD, S_RMW_WR, S_RESP
  } state_t;

  state_t      state;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        f3_ok, align_ok, range_ok, req_err;
  logic [3:0]  lanes;
  logic [31:0] lane_mask, placed, merged, word_addr;

  always_comb begin
    if (req_we) f3_ok = (req_funct3 inside {3'b000, 3'b001, 3'b010});
    else        f3_ok = (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    case (req_funct3[1:0])
      2'b01:   align_ok = ~req_addr[0];
      2'b10:   align_ok = (req_addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    range_ok = (req_addr[31:ADDR_WIDTH+2] == '0);
    req_err  = ~(f3_ok & align_ok & range_ok);
  end

  // Lane code, lane-placed store data and the RMW merge all come from the latched request.
  always_comb begin
    case (f3_q[1:0])
      2'b00:   lanes = 4'b0001 << addr_q[1:0];
      2'b01:   lanes = addr_q[1] ? 4'b1100 : 4'b0011;
      default: lanes = 4'b1111;
    endcase
    lane_mask = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
    case (f3_q[1:0])
      2'b00:   placed = {24'b0, wdata_q[7:0]} << {addr_q[1:0], 3'b000};
      2'b01:   placed = addr_q[1] ? {wdata_q[15:0], 16'b0} : {16'b0, wdata_q[15:0]};
      default: placed = wdata_q;
    endcase
    merged    = (mem_load_data & ~lane_mask) | (placed & lane_mask);
    word_addr = {2'b00, addr_q[31:2]};
  end

  // dmem controls are idle outside the memory states so a stray write can never reach dmem.
  always_comb begin
    mem_wmem       = 4'b0000;
    mem_rmem       = 5'b00000;
    mem_addr       = 32'h0;
    mem_store_data = 32'h0;
    case (state)
      S_LOAD: begin
        mem_rmem = {~f3_q[2] & ~f3_q[1], lanes};
        mem_addr = word_addr;
      end
      S_STORE: begin
        mem_wmem       = lanes;
        mem_store_data = placed;
        mem_addr       = word_addr;
      end
      S_RMW_RD: begin
        mem_rmem = 5'b01111;
        mem_addr = word_addr;
      end
      S_RMW_WR: begin
        mem_wmem       = 4'b1111;
        mem_store_data = wdata_q;
        mem_addr       = word_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            f3_q       <= req_funct3;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            resp_rdata <= 32'h0;
            if (req_err) begin
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= S_RESP;
            end else if (!req_we) begin
              state <= S_LOAD;
            end else if (req_funct3[1:0] == 2'b10 || !RMW_EN) begin
              state <= S_STORE;
            end else begin
              state <= S_RMW_RD;
            end
          end
        end
        S_LOAD: begin
          resp_rdata <= mem_load_data;
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_STORE: begin
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_RMW_RD: begin
          wdata_q <= merged;
          state   <= S_RMW_WR;
        end
        S_RMW_WR: begin
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            req_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - self-checking bench for lsu_ctrl with a behavioural dmem
// Directed vector table, hand sequences for stall/reset corners, then random traffic vs a reference model.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [3:0]  mem_wmem;
  logic [4:0]  mem_rmem;
  logic [31:0] mem_addr, mem_store_data, mem_load_data;

  logic [31:0] dmem [0:1023];
  logic [31:0] ref_mem [0:15];
  int checks = 0;
  int errors = 0;
  int wr_count = 0;

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_wmem(mem_wmem), .mem_rmem(mem_rmem), .mem_addr(mem_addr),
    .mem_store_data(mem_store_data), .mem_load_data(mem_load_data)
  );

  function automatic logic [31:0] lane_mask(input logic [3:0] w);
    return {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [4:0] rm);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] v;
    b = 8'h0;
    h = 16'h0;
    case (rm[3:0])
      4'b0001: b = w[7:0];
      4'b0010: b = w[15:8];
      4'b0100: b = w[23:16];
      4'b1000: b = w[31:24];
      4'b0011: h = w[15:0];
      4'b1100: h = w[31:16];
      default: ;
    endcase
    case (rm[3:0])
      4'b1111:                            v = w;
      4'b0011, 4'b1100:                   v = rm[4] ? {{16{h[15]}}, h} : {16'h0, h};
      4'b0001, 4'b0010, 4'b0100, 4'b1000: v = rm[4] ? {{24{b[7]}}, b} : {24'h0, b};
      default:                            v = 32'h0;
    endcase
    return v;
  endfunction

  assign mem_load_data = extract(dmem[mem_addr[9:0]], mem_rmem);

  always @(negedge clk) begin
    if (mem_wmem != 4'b0000) begin
      dmem[mem_addr[9:0]] = mem_store_data & lane_mask(mem_wmem);
      wr_count++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural result of one request, straight from the RV32I access rules.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] word,
                                output logic err, output logic [31:0] rdata,
                                output logic [31:0] nword, output int lat, output int nw);
    int size, off;
    logic legal;
    logic [31:0] v;
    off   = int'(addr % 4);
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    err   = !legal || (size > 1 && (off % size) != 0) || (addr >= (32'h1 << 17));
    rdata = 32'h0;
    nword = word;
    nw    = 0;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      v = word >> (8 * off);
      if (size == 1)      v = f3[2] ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
      else if (size == 2) v = f3[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      rdata = v;
      lat   = 2;
    end else begin
      for (int k = 0; k < size; k++) nword[8*(off+k) +: 8] = wdata[8*k +: 8];
      nw  = 1;
      lat = (size == 4) ? 2 : 3;
    end
  endfunction

  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input string tag,
                        output logic err, output logic [31:0] rdata, output int lat,
                        output logic [4:0] rm, output logic [3:0] wm, output int nw);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_ready"}, 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rm = 5'h0; wm = 4'h0; nw = 0; lat = 1;
    while (!resp_valid && lat < 10) begin
      if (mem_rmem != 5'h0) rm = mem_rmem;
      if (mem_wmem != 4'h0) begin
        wm = mem_wmem;
        nw++;
      end
      @(posedge clk); #1;
      lat++;
    end
    err   = resp_err;
    rdata = resp_rdata;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, init;
    logic        err;
    logic [31:0] rdata, fin;
    int          lat;
    logic [4:0]  rm;
    logic [3:0]  wm;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic        e, xe;
    logic [31:0] rd, xrd, xw, a, wd;
    logic [4:0]  rm;
    logic [3:0]  wm;
    logic [2:0]  f3;
    logic        we;
    int          lat, nw, xlat, xnw, idx, wc;

    vecs[0]  = '{1'b1, 3'b010, 32'h10,      32'hDEADBEEF, 32'h0,        1'b0, 32'h0,        32'hDEADBEEF, 2, 5'h00, 4'hF};
    vecs[1]  = '{1'b1, 3'b000, 32'h11,      32'h000000AA, 32'h11223344, 1'b0, 32'h0,        32'h1122AA44, 3, 5'h0F, 4'hF};
    vecs[2]  = '{1'b0, 3'b000, 32'h13,      32'h0,        32'h80FF0000, 1'b0, 32'hFFFFFF80, 32'h80FF0000, 2, 5'h18, 4'h0};
    vecs[3]  = '{1'b0, 3'b100, 32'h13,      32'h0,        32'h80FF0000, 1'b0, 32'h00000080, 32'h80FF0000, 2, 5'h08, 4'h0};
    vecs[4]  = '{1'b0, 3'b101, 32'h12,      32'h0,        32'h80FF0000, 1'b0, 32'h000080FF, 32'h80FF0000, 2, 5'h0C, 4'h0};
    vecs[5]  = '{1'b0, 3'b001, 32'h12,      32'h0,        32'h80FF0000, 1'b0, 32'hFFFF80FF, 32'h80FF0000, 2, 5'h1C, 4'h0};
    vecs[6]  = '{1'b0, 3'b010, 32'h10,      32'h0,        32'h80FF0000, 1'b0, 32'h80FF0000, 32'h80FF0000, 2, 5'h0F, 4'h0};
    vecs[7]  = '{1'b0, 3'b001, 32'h11,      32'h0,        32'h80FF0000, 1'b1, 32'h0,        32'h80FF0000, 1, 5'h00, 4'h0};
    vecs[8]  = '{1'b0, 3'b010, 32'h12,      32'h0,        32'h80FF0000, 1'b1, 32'h0,        32'h80FF0000, 1, 5'h00, 4'h0};
    vecs[9]  = '{1'b0, 3'b011, 32'h10,      32'h0,        32'h80FF0000, 1'b1, 32'h0,        32'h80FF0000, 1, 5'h00, 4'h0};
    vecs[10] = '{1'b1, 3'b001, 32'h12,      32'h1234BEEF, 32'h11223344, 1'b0, 32'h0,        32'hBEEF3344, 3, 5'h0F, 4'hF};
    vecs[11] = '{1'b0, 3'b010, 32'h20010,   32'h0,        32'h80FF0000, 1'b1, 32'h0,        32'h80FF0000, 1, 5'h00, 4'h0};
    vecs[12] = '{1'b1, 3'b100, 32'h10,      32'hFFFFFFFF, 32'h11223344, 1'b1, 32'h0,        32'h11223344, 1, 5'h00, 4'h0};
    vecs[13] = '{1'b1, 3'b000, 32'h13,      32'h0000005A, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h5AFFFFFF, 3, 5'h0F, 4'hF};
    vecs[14] = '{1'b0, 3'b010, 32'h1FFFC,   32'h0,        32'h01020304, 1'b0, 32'h01020304, 32'h01020304, 2, 5'h0F, 4'h0};

    for (int i = 0; i < 1024; i++) dmem[i] = 32'h0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", 32'(resp_err), 32'h0);
    check("rst_mem_ctl", {23'h0, mem_wmem, mem_rmem}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_store_data", mem_store_data, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_req_ready", 32'(req_ready), 32'h1);

    for (int i = 0; i < 15; i++) begin
      dmem[vecs[i].addr[11:2]] = vecs[i].init;
      do_txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, $sformatf("vec%0d", i),
             e, rd, lat, rm, wm, nw);
      check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].err));
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_rmem", i), 32'(rm), 32'(vecs[i].rm));
      check($sformatf("vec%0d_wmem", i), 32'(wm), 32'(vecs[i].wm));
      check($sformatf("vec%0d_writes", i), 32'(nw), (vecs[i].wm != 4'h0) ? 32'h1 : 32'h0);
      check($sformatf("vec%0d_word", i), dmem[vecs[i].addr[11:2]], vecs[i].fin);
    end

    // Response held under back-pressure while a second request waits.
    dmem[4] = 32'hCAFEF00D;
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(posedge clk); #1;
    req_addr = 32'h14;
    lat = 0;
    while (!resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("stall_valid_start", 32'(resp_valid), 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("stall%0d_valid", i), 32'(resp_valid), 32'h1);
      check($sformatf("stall%0d_rdata", i), resp_rdata, 32'hCAFEF00D);
      check($sformatf("stall%0d_req_ready", i), 32'(req_ready), 32'h0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_handshake_valid", 32'(resp_valid), 32'h0);
    check("stall_no_accept_in_handshake", 32'(req_ready), 32'h1);
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("stall_idle_after", 32'(req_ready), 32'h1);

    // Reset landing in RMW_RD must suppress the write.
    dmem[8] = 32'h55667788;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h22; req_wdata = 32'h0000ABCD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rmwrst_rd_rmem", 32'(mem_rmem), 32'h0F);
    wc = wr_count;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rmwrst_ctl_zero", {22'h0, req_ready, resp_valid, mem_wmem, mem_rmem}, 32'h0);
    check("rmwrst_addr_zero", mem_addr | mem_store_data | resp_rdata, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rmwrst_ready", 32'(req_ready), 32'h1);
    check("rmwrst_no_write", 32'(wr_count - wc), 32'h0);
    check("rmwrst_word8", dmem[8], 32'h55667788);

    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      dmem[i] = ref_mem[i];
    end
    for (int t = 0; t < 200; t++) begin
      idx = $urandom_range(0, 15);
      a   = {26'h0, idx[3:0], 2'(($urandom_range(0, 3)))};
      if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(17, 31));
      f3  = 3'($urandom_range(0, 7));
      we  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      model(we, f3, a, wd, ref_mem[idx], xe, xrd, xw, xlat, xnw);
      do_txn(we, f3, a, wd, $sformatf("rnd%0d", t), e, rd, lat, rm, wm, nw);
      check($sformatf("rnd%0d_err", t), 32'(e), 32'(xe));
      check($sformatf("rnd%0d_rdata", t), rd, xrd);
      check($sformatf("rnd%0d_latency", t), 32'(lat), 32'(xlat));
      check($sformatf("rnd%0d_writes", t), 32'(nw), 32'(xnw));
      check($sformatf("rnd%0d_word", t), dmem[idx], xw);
      ref_mem[idx] = xw;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
